mmind_ctrl: RTL and testbench

- Game-sequencing controller for the Mastermind datapath.
- Drives per-digit load enables for two banks of four 4-bit enabled registers: the secret bank and the guess bank.
- Collects one digit per "enter" pulse, then scores the guess against the secret over several cycles.
- Tracks guess count and flags win or lose. Sits between the debounced button/switch inputs and the register banks and display.

---
 rtl/mmind_if.sv | 27 ++
 rtl/mmind_ctrl.sv | 133 +++++++++++++
 tb/tb_mmind_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmind_if.sv
// Handshake and bank bus between the Mastermind sequencer and its register banks/display.
interface mmind_if;
    logic        enter;
    logic [3:0]  digit_in;
    logic [15:0] sec_q;
    logic [15:0] gss_q;
    logic [3:0]  sec_en;
    logic [3:0]  gss_en;
    logic [1:0]  pos;
    logic [2:0]  phase;
    logic [2:0]  exact;
    logic [2:0]  partial;
    logic [3:0]  guess_cnt;
    logic        err;
    logic        win;
    logic        lose;

    modport master (
        output enter, digit_in, sec_q, gss_q,
        input  sec_en, gss_en, pos, phase, exact, partial, guess_cnt, err, win, lose
    );

    modport slave (
        input  enter, digit_in, sec_q, gss_q,
        output sec_en, gss_en, pos, phase, exact, partial, guess_cnt, err, win, lose
    );
endinterface

// File: rtl/mmind_ctrl.sv
// Mastermind game sequencer: digit entry into secret/guess banks, multi-cycle scoring, win/lose tracking.
// state  | meaning
// SECRET | entering the four secret digits
// GUESS  | entering the four guess digits
// SCORE  | one cycle per colour, accumulating common-digit count
// RESULT | score shown, enter starts next guess
// WIN    | all four exact, enter starts new game
// LOSE   | guesses exhausted, enter starts new game
module mmind_ctrl #(
    parameter int NUM_COLORS  = 6,
    parameter int MAX_GUESSES = 10
) (
    input  logic   i_clk,
    input  logic   i_reset,
    mmind_if.slave bus
);
    typedef enum logic [2:0] {
        S_SECRET = 3'd0,
        S_GUESS  = 3'd1,
        S_SCORE  = 3'd2,
        S_RESULT = 3'd3,
        S_WIN    = 3'd4,
        S_LOSE   = 3'd5
    } state_t;

    localparam logic [4:0] LP_NC     = 5'(NUM_COLORS);
    localparam logic [3:0] LP_LAST_C = 4'(NUM_COLORS - 1);
    localparam logic [3:0] LP_MAX    = 4'(MAX_GUESSES);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_pos;
    logic [2:0] r_exact, r_partial, r_acc;
    logic [3:0] r_guess_cnt, r_color;
    logic       r_err;

    logic       w_valid, w_commit, w_last_color;
    logic [2:0] w_exact_cnt, w_sec_cnt, w_gss_cnt, w_min, w_acc_sum;
    logic [3:0] w_cnt_inc, w_sec_en, w_gss_en;

    assign w_valid      = {1'b0, bus.digit_in} < LP_NC;
    assign w_commit     = bus.enter && w_valid;
    assign w_last_color = (r_color == LP_LAST_C);
    assign w_cnt_inc    = (r_guess_cnt == LP_MAX) ? r_guess_cnt : r_guess_cnt + 4'd1;

    always_comb begin
        w_exact_cnt = 3'd0;
        w_sec_cnt   = 3'd0;
        w_gss_cnt   = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.sec_q[4*i +: 4] == bus.gss_q[4*i +: 4]) w_exact_cnt = w_exact_cnt + 3'd1;
            if (bus.sec_q[4*i +: 4] == r_color)             w_sec_cnt   = w_sec_cnt + 3'd1;
            if (bus.gss_q[4*i +: 4] == r_color)             w_gss_cnt   = w_gss_cnt + 3'd1;
        end
        w_min     = (w_sec_cnt < w_gss_cnt) ? w_sec_cnt : w_gss_cnt;
        w_acc_sum = r_acc + w_min;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sec_en    = 4'd0;
        w_gss_en    = 4'd0;
        case (r_state)
            S_SECRET: if (w_commit) begin
                w_sec_en[r_pos] = 1'b1;
                if (r_pos == 2'd3) w_state_nxt = S_GUESS;
            end
            S_GUESS: if (w_commit) begin
                w_gss_en[r_pos] = 1'b1;
                if (r_pos == 2'd3) w_state_nxt = S_SCORE;
            end
            S_SCORE: if (w_last_color) begin
                // r_exact was captured on the first colour cycle, so it is final here
                if (r_exact == 3'd4)          w_state_nxt = S_WIN;
                else if (w_cnt_inc == LP_MAX) w_state_nxt = S_LOSE;
                else                          w_state_nxt = S_RESULT;
            end
            S_RESULT: if (bus.enter) w_state_nxt = S_GUESS;
            S_WIN, S_LOSE: if (bus.enter) w_state_nxt = S_SECRET;
            default: w_state_nxt = S_SECRET;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_SECRET;
            r_pos       <= 2'd0;
            r_exact     <= 3'd0;
            r_partial   <= 3'd0;
            r_acc       <= 3'd0;
            r_guess_cnt <= 4'd0;
            r_color     <= 4'd0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= ((r_state == S_SECRET) || (r_state == S_GUESS)) && bus.enter && !w_valid;
            case (r_state)
                S_SECRET, S_GUESS: begin
                    r_color <= 4'd0;
                    r_acc   <= 3'd0;
                    if (w_commit) r_pos <= r_pos + 2'd1;
                end
                S_SCORE: begin
                    r_color <= r_color + 4'd1;
                    r_acc   <= w_acc_sum;
                    if (r_color == 4'd0) r_exact <= w_exact_cnt;
                    if (w_last_color) begin
                        r_partial   <= w_acc_sum - r_exact;
                        r_guess_cnt <= w_cnt_inc;
                    end
                end
                S_RESULT: if (bus.enter) r_pos <= 2'd0;
                S_WIN, S_LOSE: if (bus.enter) begin
                    r_pos       <= 2'd0;
                    r_guess_cnt <= 4'd0;
                    r_exact     <= 3'd0;
                    r_partial   <= 3'd0;
                end
                default: r_pos <= 2'd0;
            endcase
        end
    end

    assign bus.sec_en    = w_sec_en;
    assign bus.gss_en    = w_gss_en;
    assign bus.pos       = r_pos;
    assign bus.phase     = r_state;
    assign bus.exact     = r_exact;
    assign bus.partial   = r_partial;
    assign bus.guess_cnt = r_guess_cnt;
    assign bus.err       = r_err;
    assign bus.win       = (r_state == S_WIN);
    assign bus.lose      = (r_state == S_LOSE);
endmodule

// File: tb/tb_mmind_ctrl.sv
// Bench for mmind_ctrl: register banks, game-level reference model, per-cycle compare, directed and random play.
module tb_mmind_ctrl;
    localparam int NC   = 6;
    localparam int MAXG = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmind_if bus();

    mmind_ctrl #(.NUM_COLORS(NC), .MAX_GUESSES(MAXG)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus.slave)
    );

    logic [3:0] sec_bank [4];
    logic [3:0] gss_bank [4];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                sec_bank[i] <= 4'd0;
                gss_bank[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sec_en[i]) sec_bank[i] <= bus.digit_in;
                if (bus.gss_en[i]) gss_bank[i] <= bus.digit_in;
            end
        end
    end
    assign bus.sec_q = {sec_bank[3], sec_bank[2], sec_bank[1], sec_bank[0]};
    assign bus.gss_q = {gss_bank[3], gss_bank[2], gss_bank[1], gss_bank[0]};

    int n_pass = 0;
    int n_tot  = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Game-level model: phase 0..5, entry position, stored digits, score, remaining score cycles
    int m_ph, m_pos, m_cnt, m_ex, m_pa, m_left;
    int m_sec [4];
    int m_gss [4];
    int m_err;

    function automatic int common_total();
        int t = 0;
        for (int c = 0; c < NC; c++) begin
            int cs = 0, cg = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_sec[i] == c) cs++;
                if (m_gss[i] == c) cg++;
            end
            t += (cs < cg) ? cs : cg;
        end
        return t;
    endfunction

    always @(posedge clk or posedge rst) begin
        int d;
        if (rst) begin
            m_ph = 0; m_pos = 0; m_cnt = 0; m_ex = 0; m_pa = 0; m_err = 0; m_left = 0;
        end else begin
            d = int'(bus.digit_in);
            m_err = 0;
            case (m_ph)
                0, 1: if (bus.enter) begin
                    if (d >= NC) m_err = 1;
                    else begin
                        if (m_ph == 0) m_sec[m_pos] = d; else m_gss[m_pos] = d;
                        if (m_pos == 3) begin
                            m_pos = 0;
                            m_ph++;
                            m_left = NC;
                        end else m_pos++;
                    end
                end
                2: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ex = 0;
                        for (int i = 0; i < 4; i++) if (m_sec[i] == m_gss[i]) m_ex++;
                        m_pa  = common_total() - m_ex;
                        m_cnt = (m_cnt + 1 > MAXG) ? MAXG : m_cnt + 1;
                        m_ph  = (m_ex == 4) ? 4 : ((m_cnt == MAXG) ? 5 : 3);
                    end
                end
                3: if (bus.enter) begin
                    m_ph = 1; m_pos = 0;
                end
                default: if (bus.enter) begin
                    m_ph = 0; m_pos = 0; m_cnt = 0; m_ex = 0; m_pa = 0;
                end
            endcase
        end
    end

    function automatic int exp_en(input int ph);
        if (m_ph == ph && bus.enter && int'(bus.digit_in) < NC) return 1 << m_pos;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("phase",     bus.phase,     m_ph);
            chk("pos",       bus.pos,       m_pos);
            chk("guess_cnt", bus.guess_cnt, m_cnt);
            chk("err",       bus.err,       m_err);
            chk("win",       bus.win,       int'(m_ph == 4));
            chk("lose",      bus.lose,      int'(m_ph == 5));
            chk("sec_en",    bus.sec_en,    exp_en(0));
            chk("gss_en",    bus.gss_en,    exp_en(1));
            if (m_ph != 2) begin
                chk("exact",   bus.exact,   m_ex);
                chk("partial", bus.partial, m_pa);
            end
        end
    end

    task automatic press(input int d);
        bus.digit_in = 4'(d);
        bus.enter    = 1'b1;
        @(posedge clk); #1;
        bus.enter    = 1'b0;
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1; #2; rst = 1'b0;
    endtask

    initial begin
        int r, r2;
        bus.enter    = 1'b0;
        bus.digit_in = 4'd0;
        rst          = 1'b1;
        #12;
        chk("rst_phase", bus.phase, 0);
        chk("rst_cnt",   bus.guess_cnt, 0);
        chk("rst_en",    bus.sec_en, 0);
        rst = 1'b0;
        idle(1);

        // Secret entry walks the one-hot enable
        for (int k = 0; k < 4; k++) begin
            bus.digit_in = 4'(k + 1);
            bus.enter    = 1'b1;
            #1 chk("sec_en_walk", bus.sec_en, 1 << k);
            @(posedge clk); #1;
            bus.enter = 1'b0;
        end
        chk("to_guess_phase", bus.phase, 1);
        chk("to_guess_pos",   bus.pos,   0);

        enter4(4, 3, 2, 1);
        idle(5);
        chk("score_busy", bus.phase, 2);
        idle(1);
        chk("rev_phase",   bus.phase,     3);
        chk("rev_exact",   bus.exact,     0);
        chk("rev_partial", bus.partial,   4);
        chk("rev_cnt",     bus.guess_cnt, 1);
        press(0);
        chk("ack_guess", bus.phase, 1);

        do_reset();
        enter4(1, 1, 2, 2); enter4(1, 2, 1, 5); idle(6);
        chk("dup_exact",   bus.exact,   1);
        chk("dup_partial", bus.partial, 2);

        do_reset();
        enter4(0, 0, 0, 0); enter4(0, 5, 5, 5); idle(6);
        chk("zero_exact",   bus.exact,   1);
        chk("zero_partial", bus.partial, 0);

        do_reset();
        enter4(3, 0, 5, 1); enter4(3, 0, 5, 1); idle(6);
        chk("win_phase", bus.phase, 4);
        chk("win_flag",  bus.win,   1);
        press(2);
        chk("new_phase", bus.phase,     0);
        chk("new_cnt",   bus.guess_cnt, 0);
        chk("new_exact", bus.exact,     0);

        // Illegal digit mid-guess, then exhaust all guesses
        do_reset();
        enter4(1, 2, 3, 4);
        press(0); press(0);
        bus.digit_in = 4'd7;
        bus.enter    = 1'b1;
        #1 chk("bad_gss_en", bus.gss_en, 0);
        @(posedge clk); #1;
        bus.enter = 1'b0;
        chk("bad_pos", bus.pos, 2);
        chk("bad_err", bus.err, 1);
        idle(1);
        chk("err_clear", bus.err, 0);
        press(0); press(0);
        for (int g = 0; g < MAXG; g++) begin
            if (g > 0) begin
                press(0);
                enter4(5, 5, 5, 5);
            end
            idle(NC);
            chk("lose_cnt", bus.guess_cnt, g + 1);
        end
        chk("lose_phase", bus.phase, 5);
        chk("lose_flag",  bus.lose,  1);
        press(1);

        // enter ignored during SCORE, then async reset mid-SCORE
        do_reset();
        enter4(1, 2, 3, 4); enter4(1, 3, 2, 4); idle(6);
        chk("pre_exact",   bus.exact,   2);
        chk("pre_partial", bus.partial, 2);
        press(0);
        enter4(1, 2, 4, 3);
        bus.digit_in = 4'd2;
        bus.enter    = 1'b1;
        #1 chk("score_gss_en", bus.gss_en, 0);
        chk("score_sec_en", bus.sec_en, 0);
        @(posedge clk); #1;
        bus.enter = 1'b0;
        idle(1);
        #2 rst = 1'b1;
        #1;
        chk("arst_phase",   bus.phase,     0);
        chk("arst_cnt",     bus.guess_cnt, 0);
        chk("arst_exact",   bus.exact,     0);
        chk("arst_partial", bus.partial,   0);
        chk("arst_pos",     bus.pos,       0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Random play against the model
        for (int it = 0; it < 3000; it++) begin
            bus.enter = 1'b0;
            r = $urandom_range(0, 299);
            if (r == 0) do_reset();
            r2 = $urandom_range(0, 99);
            if (r2 < 45) begin
                bus.enter = 1'b1;
                if (r2 < 4)                      bus.digit_in = 4'($urandom_range(NC, 15));
                else if (m_ph == 1 && r2 < 25)   bus.digit_in = 4'(m_sec[m_pos]);
                else                             bus.digit_in = 4'($urandom_range(0, NC - 1));
            end else begin
                bus.digit_in = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
        end
        bus.enter = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
